clock_div_switch: RTL

CLOCK_DIV_SWITCH -- requirements
Module: clock_div_switch

---
 rtl/clock_div_switch_pkg.sv | 15 +
 rtl/clock_div_switch_cnt.sv | 34 +++
 rtl/clock_div_switch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/clock_div_switch_pkg.sv
// Shared definitions for the glitch-free switchable clock divider.
// Holds the switch FSM state encoding used by the top-level controller.
package clock_div_switch_pkg;

    localparam int STATE_W = 2;

    // RUN: divide on the active channel; DRAIN: finish the high phase on the
    // old channel; GAP: hold clk_out low before handing over to the target.
    typedef enum logic [STATE_W-1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/clock_div_switch_cnt.sv
// Half-period counter with a greater-or-equal compare against the active limit.
// The >= compare lets a shrinking limit take effect at the next compare
// instead of waiting for the counter to wrap.
module clock_div_switch_cnt
    import clock_div_switch_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [DIV_W-1:0] limit_i,
    output logic             hit_o
);

    logic [DIV_W-1:0] cnt_q;

    // Count up while enabled; clear wins so a toggle always restarts at zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state flops use <= so every flop samples pre-edge values,
        // independent of the order the always blocks are evaluated in.
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

    assign hit_o = (cnt_q >= limit_i);

endmodule

// File: rtl/clock_div_switch.sv
// Switchable clock divider: NUM_SEL channels, each with half-period
// div_cfg[i]+1 clk cycles. A channel change drains the current high phase,
// forces a GAP_CYC-cycle low gap, then hands over so no runt pulse appears.
// Optional feature: define CLOCK_DIV_SWITCH_CNT_EN to add a saturating
// switch_cnt[7:0] output counting completed switches.
module clock_div_switch
    import clock_div_switch_pkg::*;
#(
    parameter  int NUM_SEL = 4,
    parameter  int DIV_W   = 8,
    parameter  int GAP_CYC = 2,
    localparam int SEL_W   = $clog2(NUM_SEL)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SEL*DIV_W-1:0] div_cfg,
    output logic                     clk_out,
    output logic [SEL_W-1:0]         sel_active,
    output logic                     busy,
    output logic                     switch_done
`ifdef CLOCK_DIV_SWITCH_CNT_EN
    ,
    output logic [7:0]               switch_cnt
`endif
);

    localparam int          GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_e           state_q;
    logic             clk_out_q;
    logic [SEL_W-1:0] sel_active_q;
    logic [SEL_W-1:0] target_q;
    logic [GAP_W-1:0] gap_q;
    logic             busy_q;
    logic             done_q;
    logic             armed_q;

    logic [DIV_W-1:0] limit;
    logic             sel_ok;
    logic             req;
    logic             gap_exit;
    logic             cnt_hit;
    logic             cnt_clear;
    logic             cnt_inc;

    assign limit    = div_cfg[int'(sel_active_q) * DIV_W +: DIV_W];
    assign sel_ok   = (int'(sel) < NUM_SEL);
    // armed_q masks the first cycle after reset so ch0 always starts cleanly.
    assign req      = armed_q && (sel != sel_active_q) && sel_ok;
    assign gap_exit = (state_q == GAP) && (gap_q == GAP_LAST);

    // Counter control: run on the active channel, hold at zero through GAP.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            RUN: begin
                if ((req && !clk_out_q) || cnt_hit) cnt_clear = 1'b1;
                else                                cnt_inc   = 1'b1;
            end
            DRAIN: begin
                if (cnt_hit) cnt_clear = 1'b1;
                else         cnt_inc   = 1'b1;
            end
            default: cnt_clear = 1'b1;
        endcase
    end

    clock_div_switch_cnt #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .limit_i (limit),
        .hit_o   (cnt_hit)
    );

    // Switch FSM with registered clk_out, busy and switch_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            clk_out_q    <= 1'b0;
            sel_active_q <= '0;
            target_q     <= '0;
            gap_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (req) begin
                        target_q <= sel;
                        busy_q   <= 1'b1;
                        // A high phase that ends on this very edge needs no drain.
                        if (!clk_out_q || cnt_hit) begin
                            clk_out_q <= 1'b0;
                            gap_q     <= '0;
                            state_q   <= GAP;
                        end else begin
                            state_q   <= DRAIN;
                        end
                    end else if (cnt_hit) begin
                        clk_out_q <= ~clk_out_q;
                    end
                end
                DRAIN: begin
                    if (cnt_hit) begin
                        clk_out_q <= 1'b0;
                        gap_q     <= '0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_exit) begin
                        sel_active_q <= target_q;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= RUN;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign clk_out     = clk_out_q;
    assign sel_active  = sel_active_q;
    assign busy        = busy_q;
    assign switch_done = done_q;

`ifdef CLOCK_DIV_SWITCH_CNT_EN
    logic [7:0] switch_cnt_q;

    // Saturating count of completed switches, stepping with switch_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            switch_cnt_q <= '0;
        end else if (gap_exit && (switch_cnt_q != 8'hFF)) begin
            switch_cnt_q <= switch_cnt_q + 8'd1;
        end
    end

    assign switch_cnt = switch_cnt_q;
`endif

endmodule
